// File: rtl/fix2flt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fix2flt_pkg
// Description : Shared constants and FSM state encoding for the sequential
//               sign-magnitude fixed-point to IEEE half-precision converter.
// Revision    : 1.0 - initial release
// ============================================================================
package fix2flt_pkg;

  // Half-precision exponent bias
  localparam int FLT_BIAS = 15;
  // Fractional bits of the fixed-point input (LSB weight 2^-8)
  localparam int FIX_FRAC = 8;
  // Width of the fixed-point magnitude field
  localparam int MAG_W    = 15;
  // Width of the half-precision mantissa field
  localparam int MAN_W    = 10;
  // Width of the half-precision exponent field
  localparam int EXP_W    = 5;
  // Width of the normalisation shift counter
  localparam int CNT_W    = 4;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RD_LO = 4'd1,
    ST_RD_HI = 4'd2,
    ST_CAP   = 4'd3,
    ST_NORM  = 4'd4,
    ST_ROUND = 4'd5,
    ST_WR_LO = 4'd6,
    ST_WR_HI = 4'd7,
    ST_DONE  = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fix2flt_round.sv
`default_nettype none
// ============================================================================
// Module      : fix2flt_round
// Description : Combinational round-to-nearest-even of a truncated mantissa,
//               with mantissa carry folded into the exponent.
// Revision    : 1.0 - initial release
// ============================================================================
module fix2flt_round
  import fix2flt_pkg::*;
(
  input  logic [MAN_W-1:0] mant,
  input  logic             guard,
  input  logic             sticky,
  input  logic [EXP_W-1:0] exp,
  output logic [MAN_W-1:0] mant_r,
  output logic [EXP_W-1:0] exp_r
);

  logic             w_inc;
  logic [MAN_W:0]   w_sum;

  // Round up above the halfway point, or exactly at it when the LSB is odd
  assign w_inc = guard & (sticky | mant[0]);
  assign w_sum = {1'b0, mant} + {{MAN_W{1'b0}}, w_inc};

  // A carry out of the mantissa renormalises to 1.0 x 2^(exp+1)
  always_comb begin
    mant_r = w_sum[MAN_W-1:0];
    exp_r  = exp;
    if (w_sum[MAN_W]) begin
      mant_r = '0;
      exp_r  = exp + EXP_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fix2flt_seq.sv
`default_nettype none
// ============================================================================
// Module      : fix2flt_seq
// Description : Memory-mapped sequencer that reads a 16-bit sign-magnitude
//               fixed-point word (8 fractional bits), normalises it one bit
//               per cycle, rounds to nearest-even and writes back an IEEE
//               half-precision result, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module fix2flt_seq
  import fix2flt_pkg::*;
#(
  parameter logic [7:0] IN_ADDR  = 8'd0,
  parameter logic [7:0] OUT_ADDR = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] dm_addr,
  output logic       dm_rd,
  output logic       dm_wr,
  output logic [7:0] dm_wdata,
  input  logic [7:0] dm_rdata
);

  // Exponent of a magnitude whose leading one sits in bit MAG_W-1 with no shift
  localparam logic [EXP_W-1:0] c_EXP_TOP = EXP_W'(FLT_BIAS + MAG_W - 1 - FIX_FRAC);

  state_t             r_state;
  logic               r_start_q;
  logic [7:0]         r_lo;
  logic               r_sign;
  logic [MAG_W-1:0]   r_mag;
  logic [CNT_W-1:0]   r_s;
  logic [7:0]         r_res_hi;

  logic [EXP_W-1:0]   w_exp;
  logic [MAN_W-1:0]   w_mant;
  logic               w_guard;
  logic               w_sticky;
  logic [MAN_W-1:0]   w_mant_r;
  logic [EXP_W-1:0]   w_exp_r;
  logic [15:0]        w_result;
  logic               w_mag_zero;

  // Field extraction from the normalised magnitude; bit MAG_W-1 is the hidden one
  assign w_mag_zero = (r_mag == '0);
  assign w_exp      = c_EXP_TOP - {1'b0, r_s};
  assign w_mant     = r_mag[13:4];
  assign w_guard    = r_mag[3];
  assign w_sticky   = |r_mag[2:0];

  fix2flt_round u_round (
    .mant   (w_mant),
    .guard  (w_guard),
    .sticky (w_sticky),
    .exp    (w_exp),
    .mant_r (w_mant_r),
    .exp_r  (w_exp_r)
  );

  // Zero magnitude bypasses rounding and keeps its sign
  assign w_result = w_mag_zero ? {r_sign, 15'h0} : {r_sign, w_exp_r, w_mant_r};

  // Sequencer: state, datapath and registered memory-bus outputs for the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_start_q <= 1'b0;
      r_lo      <= '0;
      r_sign    <= 1'b0;
      r_mag     <= '0;
      r_s       <= '0;
      r_res_hi  <= '0;
      done      <= 1'b0;
      dm_addr   <= '0;
      dm_rd     <= 1'b0;
      dm_wr     <= 1'b0;
      dm_wdata  <= '0;
    end else begin
      r_start_q <= start;
      done      <= 1'b0;
      dm_addr   <= '0;
      dm_rd     <= 1'b0;
      dm_wr     <= 1'b0;
      dm_wdata  <= '0;
      case (r_state)
        ST_IDLE: begin
          // Requests are falling edges of start, seen only here
          if (r_start_q && !start) begin
            r_state <= ST_RD_LO;
            r_mag   <= '0;
            r_s     <= '0;
            dm_rd   <= 1'b1;
            dm_addr <= IN_ADDR;
          end
        end
        ST_RD_LO: begin
          r_state <= ST_RD_HI;
          dm_rd   <= 1'b1;
          dm_addr <= IN_ADDR + 8'd1;
        end
        ST_RD_HI: begin
          r_lo    <= dm_rdata;
          r_state <= ST_CAP;
        end
        ST_CAP: begin
          r_sign  <= dm_rdata[7];
          r_mag   <= {dm_rdata[6:0], r_lo};
          r_state <= ST_NORM;
        end
        ST_NORM: begin
          if (r_mag[MAG_W-1] || w_mag_zero) begin
            r_state <= ST_ROUND;
          end else begin
            r_mag <= {r_mag[MAG_W-2:0], 1'b0};
            r_s   <= r_s + CNT_W'(1);
          end
        end
        ST_ROUND: begin
          r_res_hi <= w_result[15:8];
          r_state  <= ST_WR_LO;
          dm_wr    <= 1'b1;
          dm_addr  <= OUT_ADDR;
          dm_wdata <= w_result[7:0];
        end
        ST_WR_LO: begin
          r_state  <= ST_WR_HI;
          dm_wr    <= 1'b1;
          dm_addr  <= OUT_ADDR + 8'd1;
          dm_wdata <= r_res_hi;
        end
        ST_WR_HI: begin
          r_state <= ST_DONE;
          done    <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fix2flt_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fix2flt_seq
// Description : Self-checking bench for fix2flt_seq with a byte memory model
//               and an expected-result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fix2flt_seq;

  localparam logic [7:0] c_IN  = 8'd0;
  localparam logic [7:0] c_OUT = 8'd4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] dm_addr;
  logic       dm_rd;
  logic       dm_wr;
  logic [7:0] dm_wdata;
  logic [7:0] dm_rdata;

  logic [7:0] mem [0:255];

  logic [15:0] q_res [$];
  int          q_lat [$];

  int n_vec = 0;
  int n_err = 0;

  fix2flt_seq #(.IN_ADDR(c_IN), .OUT_ADDR(c_OUT)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .done     (done),
    .dm_addr  (dm_addr),
    .dm_rd    (dm_rd),
    .dm_wr    (dm_wr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous byte memory: registered read, write on the same edge
  always @(posedge clk) begin
    if (dm_rd) dm_rdata <= mem[dm_addr];
    if (dm_wr) mem[dm_addr] <= dm_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int msb_pos(input logic [14:0] m);
    int p;
    p = -1;
    for (int k = 0; k < 15; k++) if (m[k]) p = k;
    return p;
  endfunction

  // Normalisation shift count implied by the leading-one position
  function automatic int ref_s(input logic [15:0] w);
    int p;
    p = msb_pos(w[14:0]);
    return (p < 0) ? 0 : 14 - p;
  endfunction

  // Reference conversion by leading-one position and explicit remainder compare
  function automatic logic [15:0] ref_fp16(input logic [15:0] w);
    int p, e, man, rem, half, m_i;
    logic [31:0] ev, mv;
    m_i = {17'd0, w[14:0]};
    p = msb_pos(w[14:0]);
    if (p < 0) return {w[15], 15'h0};
    e = p + 7;
    if (p > 10) begin
      man  = (m_i >> (p - 10)) & 'h3FF;
      rem  = m_i & ((1 << (p - 10)) - 1);
      half = 1 << (p - 11);
      if (rem > half || (rem == half && (man % 2) == 1)) man++;
    end else begin
      man = (m_i << (10 - p)) & 'h3FF;
    end
    if (man == 'h400) begin
      man = 0;
      e++;
    end
    ev = e;
    mv = man;
    return {w[15], ev[4:0], mv[9:0]};
  endfunction

  task automatic load(input logic [15:0] w);
    mem[c_IN]           = w[7:0];
    mem[c_IN + 8'd1]    = w[15:8];
    mem[c_OUT]          = 8'hA5;
    mem[c_OUT + 8'd1]   = 8'h5A;
    q_res.push_back(ref_fp16(w));
    q_lat.push_back(7 + ref_s(w));
  endtask

  // Watch n cycles for any spurious done pulse or memory write
  task automatic quiet(input string tag, input int n);
    int nd;
    nd = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done || dm_wr) nd++;
    end
    chk(tag, nd, 0);
  endtask

  task automatic run_op(input logic [15:0] w, input bit toggle);
    logic [15:0] r_exp;
    int lat_exp, got;
    bit seen;
    load(w);
    lat_exp = 7 + ref_s(w);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 1'b0;
    got  = -1;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (toggle && i == 9)  start = 1'b1;
      if (toggle && i == 10) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        got  = i - 1;
        if (toggle) start = 1'b0;
      end else if (toggle && i == lat_exp) begin
        start = 1'b1;
      end
    end
    r_exp   = q_res.pop_front();
    lat_exp = q_lat.pop_front();
    chk($sformatf("done_seen_%h", w), {31'd0, seen}, 1);
    if (seen) begin
      chk($sformatf("latency_%h", w), got, lat_exp);
      chk($sformatf("res_lo_%h", w), {24'd0, mem[c_OUT]}, {24'd0, r_exp[7:0]});
      chk($sformatf("res_hi_%h", w), {24'd0, mem[c_OUT + 8'd1]}, {24'd0, r_exp[15:8]});
      @(posedge clk); #1;
      chk($sformatf("done_width_%h", w), {31'd0, done}, 0);
    end
    quiet($sformatf("no_extra_%h", w), toggle ? 25 : 2);
  endtask

  task automatic reset_in_norm(input logic [15:0] w);
    load(w);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_dm_rd", {31'd0, dm_rd}, 0);
    chk("rst_dm_wr", {31'd0, dm_wr}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_dm_addr", {24'd0, dm_addr}, 0);
    quiet("rst_quiet", 3);
    chk("rst_out_lo", {24'd0, mem[c_OUT]}, 32'hA5);
    chk("rst_out_hi", {24'd0, mem[c_OUT + 8'd1]}, 32'h5A);
    void'(q_res.pop_front());
    void'(q_lat.pop_front());
    @(negedge clk) reset = 1'b1;
    quiet("post_rst_quiet", 3);
  endtask

  initial begin
    logic [15:0] vec [7] = '{16'h0100, 16'h8180, 16'h7FFF, 16'h4008,
                             16'h0001, 16'h8000, 16'h0000};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_dm_rd", {31'd0, dm_rd}, 0);
    chk("reset_dm_wr", {31'd0, dm_wr}, 0);
    chk("reset_dm_addr", {24'd0, dm_addr}, 0);
    chk("reset_dm_wdata", {24'd0, dm_wdata}, 0);
    @(negedge clk) reset = 1'b1;
    quiet("idle_quiet", 3);

    for (int i = 0; i < 7; i++) run_op(vec[i], 1'b0);
    run_op(16'h0001, 1'b1);
    reset_in_norm(16'h0003);
    run_op(16'h0100, 1'b0);
    for (int i = 0; i < 16; i++) run_op(16'($urandom), 1'b0);
    run_op(16'h00FF, 1'b0);
    run_op(16'h8018, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fix2flt_seq.md
FIX2FLT_SEQ -- requirements
Module: fix2flt_seq

Interface
REQ-001 Parameter IN_ADDR, default 8'd0, SHALL set the data-memory byte address of the input low byte; the high byte is at IN_ADDR+1.
REQ-002 Parameter OUT_ADDR, default 8'd4, SHALL set the data-memory byte address of the result low byte; the high byte is at OUT_ADDR+1.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be the request level from the test bench.
REQ-006 done  output  1  SHALL be a one-cycle acknowledge pulse.
REQ-007 dm_addr  output  8  SHALL be the data-memory byte address.
REQ-008 dm_rd  output  1  SHALL be the read enable; read data returns one cycle later.
REQ-009 dm_wr  output  1  SHALL be the write enable; the write commits on the same edge.
REQ-010 dm_wdata  output  8  SHALL be the write data.
REQ-011 dm_rdata  input  8  SHALL be the registered read data.

Function
REQ-012 Input word {hi,lo} SHALL be sign-magnitude fixed point: bit15 is the sign; bits14:0 are the magnitude with LSB weight 2^-8.
REQ-013 Output SHALL be IEEE half precision: sign in bit15, exponent in bits14:10 with bias 15, mantissa in bits9:0; no subnormal, infinity or NaN results are possible.
REQ-014 start SHALL be registered every cycle into start_q; a request is the falling edge (start_q=1, start=0), accepted only in IDLE.
REQ-015 FSM states SHALL be IDLE, RD_LO, RD_HI, CAP, NORM, ROUND, WR_LO, WR_HI, DONE, traversed in that order.
REQ-016 RD_LO SHALL drive dm_addr=IN_ADDR with dm_rd=1.
REQ-017 RD_HI SHALL drive dm_addr=IN_ADDR+1 with dm_rd=1 and capture the low byte.
REQ-018 CAP SHALL capture the high byte into sign and a 15-bit magnitude register.
REQ-019 NORM SHALL shift the magnitude left by one bit per cycle and increment a 4-bit counter s while bit14=0 and magnitude≠0.
REQ-020 NORM SHALL exit to ROUND the first cycle bit14=1 or magnitude=0, giving s+1 cycles in NORM (s in 0..14).
REQ-021 ROUND SHALL form exp=21-s, mant=mag[13:4], guard=mag[3] and sticky=|mag[2:0].
REQ-022 ROUND SHALL apply round-to-nearest-even: increment when guard && (sticky || mant[0]).
REQ-023 A mantissa carry SHALL clear mant and increment exp; the maximum result exponent is 22.
REQ-024 Zero magnitude SHALL yield {sign,15'h0}, i.e. signed zero is preserved.
REQ-025 WR_LO SHALL write result[7:0] to OUT_ADDR; WR_HI SHALL write result[15:8] to OUT_ADDR+1.
REQ-026 DONE SHALL hold done=1 for exactly one cycle, then return to IDLE.
REQ-027 done SHALL assert 7+s rising edges after the accepting edge.
REQ-028 Start edges outside IDLE, including during DONE, SHALL be ignored and not queued.
REQ-029 dm_rd, dm_wr and done SHALL be 0 in every state not listed as driving them.
REQ-030 dm_addr SHALL be 0 when idle.

Reset
REQ-031 Asserting reset SHALL immediately force IDLE with start_q=0, done=0, dm_rd=0, dm_wr=0, dm_addr=0, dm_wdata=0, and all datapath registers cleared.
REQ-032 Reset mid-operation SHALL abort without further memory access; a byte already written remains, and no done is issued.
REQ-033 After reset deasserts, the first accepted request SHALL require start to be sampled high and then low.

Structure
REQ-034 Package fix2flt_pkg SHALL hold the state enum and the constants FLT_BIAS=15, FIX_FRAC=8, MAG_W=15 and MAN_W=10.
REQ-035 Rounding SHALL live in one combinational sub-module fix2flt_round (inputs mant, guard, sticky, exp; outputs mant_r, exp_r).
REQ-036 The block SHALL be synthesizable, with no delays or waits.

Verification
REQ-037 Input 0x0100 (+1.0) -> output 0x3C00; s=6; done 13 edges after acceptance.
REQ-038 Input 0x8180 (-1.5) -> output 0xBE00.
REQ-039 Input 0x7FFF -> rounding carry -> output 0x5800; input 0x4008 (tie, even) -> output 0x5400.
REQ-040 Input 0x0001 -> output 0x1C00; s=14; done 21 edges after acceptance. Input 0x8000 -> output 0x8000.
REQ-041 Start toggled during NORM -> ignored, single done, memory bytes correct.
REQ-042 Reset asserted in NORM -> outputs 0 immediately, no write to OUT_ADDR/OUT_ADDR+1, next request completes normally.
